// File: rtl/sensor_event_conditioner.sv
// Synchronizes and debounces the goal beam-break and goalie limit-switch inputs, and turns
// beam interruptions into single goal events with a post-goal holdoff, a saturating count and a sticky flag.
module sensor_event_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLDOFF_CYCLES  = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        beam_break_raw,
    input  logic        limit_switch_raw,
    input  logic        clear_goal,
    output logic        beam_broken,
    output logic        limit_pressed,
    output logic        goal_event,
    output logic [7:0]  goal_count,
    output logic [31:0] status
);

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [26:0] HO_LOAD = 27'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BROKEN  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t      state;
    logic [26:0] holdoff_timer;
    logic        holdoff_active;
    logic        goal_flag;

    logic        beam_sync_p0, beam_sync_p1;
    logic        limit_sync_p0, limit_sync_p1;
    logic [15:0] beam_cnt, limit_cnt;
    logic [16:0] beam_db_nxt, limit_db_nxt;
    logic        beam_level_nxt;

    // Returns {next_level, next_count} for one debouncer step.
    function automatic logic [16:0] debounce_step(input logic sample, input logic level,
                                                  input logic [15:0] cnt);
        if (sample == level)
            return {level, 16'd0};
        else if (cnt == DB_LAST)
            return {sample, 16'd0};
        else
            return {level, cnt + 16'd1};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Stage p0/p1: two-flop synchronizers; beam idles intact (1), limit idles released (0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beam_sync_p0  <= 1'b1;
            beam_sync_p1  <= 1'b1;
            limit_sync_p0 <= 1'b0;
            limit_sync_p1 <= 1'b0;
        end else begin
            beam_sync_p0  <= beam_break_raw;
            beam_sync_p1  <= beam_sync_p0;
            limit_sync_p0 <= limit_switch_raw;
            limit_sync_p1 <= limit_sync_p0;
        end
    end

    // Beam sensor is active-low: a synced 0 means broken.
    assign beam_db_nxt    = debounce_step(~beam_sync_p1, beam_broken, beam_cnt);
    assign limit_db_nxt   = debounce_step(limit_sync_p1, limit_pressed, limit_cnt);
    assign beam_level_nxt = beam_db_nxt[16];

    // Debounced levels and the beam FSM; the FSM reacts to the next debounced level so
    // goal_event lands on the same edge that beam_broken rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beam_cnt       <= 16'd0;
            limit_cnt      <= 16'd0;
            beam_broken    <= 1'b0;
            limit_pressed  <= 1'b0;
            state          <= IDLE;
            holdoff_timer  <= 27'd0;
            holdoff_active <= 1'b0;
            goal_event     <= 1'b0;
            goal_count     <= 8'd0;
            goal_flag      <= 1'b0;
        end else begin
            beam_broken   <= beam_db_nxt[16];
            beam_cnt      <= beam_db_nxt[15:0];
            limit_pressed <= limit_db_nxt[16];
            limit_cnt     <= limit_db_nxt[15:0];
            goal_event    <= 1'b0;

            if (clear_goal) begin
                goal_count <= 8'd0;
                goal_flag  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    holdoff_active <= 1'b0;
                    if (beam_level_nxt) begin
                        goal_event <= 1'b1;
                        goal_flag  <= 1'b1;
                        goal_count <= clear_goal ? 8'd1 : sat_inc(goal_count);
                        state      <= BROKEN;
                    end
                end
                BROKEN: begin
                    holdoff_active <= 1'b0;
                    if (!beam_level_nxt) begin
                        holdoff_timer  <= HO_LOAD;
                        holdoff_active <= 1'b1;
                        state          <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (beam_level_nxt) begin
                        holdoff_active <= 1'b0;
                        state          <= BROKEN;
                    end else if (holdoff_timer == 27'd0) begin
                        holdoff_active <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        holdoff_timer <= holdoff_timer - 27'd1;
                    end
                end
                default: begin
                    holdoff_active <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    assign status = {16'd0, goal_count, 4'd0, holdoff_active, goal_flag, limit_pressed, beam_broken};

endmodule

// File: tb/tb_sensor_event_conditioner.sv
// Directed self-checking bench for sensor_event_conditioner with DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8.
module tb_sensor_event_conditioner;

    logic        clk;
    logic        reset_n;
    logic        beam_break_raw;
    logic        limit_switch_raw;
    logic        clear_goal;
    logic        beam_broken;
    logic        limit_pressed;
    logic        goal_event;
    logic [7:0]  goal_count;
    logic [31:0] status;

    int checks;
    int failures;
    int ev_cnt;
    int ev0;

    sensor_event_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLDOFF_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .beam_break_raw  (beam_break_raw),
        .limit_switch_raw(limit_switch_raw),
        .clear_goal      (clear_goal),
        .beam_broken     (beam_broken),
        .limit_pressed   (limit_pressed),
        .goal_event      (goal_event),
        .goal_count      (goal_count),
        .status          (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each pulse is seen at the posedge that ends it.
    initial ev_cnt = 0;
    always @(posedge clk) if (goal_event === 1'b1) ev_cnt++;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; beam_break_raw = 1'b1; limit_switch_raw = 1'b0; clear_goal = 1'b0;
        wait_cycles(3);
        checks++;
        if (status !== 32'h0) begin failures++; $display("FAIL reset_in status got=%h exp=%h", status, 32'h0); end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_cycles(1);
            checks++;
            if (status !== 32'h0) begin failures++; $display("FAIL reset_idle_status cyc=%0d got=%h exp=%h", i, status, 32'h0); end
            checks++;
            if (goal_event !== 1'b0) begin failures++; $display("FAIL reset_idle_event cyc=%0d got=%b exp=0", i, goal_event); end
        end
    endtask

    task automatic test_glitch;
        limit_switch_raw = 1'b1;
        wait_cycles(10);
        ev0 = ev_cnt;
        beam_break_raw = 1'b0;
        wait_cycles(3);
        beam_break_raw = 1'b1;
        wait_cycles(12);
        checks++;
        if (beam_broken !== 1'b0) begin failures++; $display("FAIL glitch_level got=%b exp=0", beam_broken); end
        checks++;
        if (ev_cnt - ev0 !== 0) begin failures++; $display("FAIL glitch_events got=%0d exp=0", ev_cnt - ev0); end

        beam_break_raw = 1'b0;
        wait_cycles(5);
        checks++;
        if (beam_broken !== 1'b0) begin failures++; $display("FAIL break_early got=%b exp=0", beam_broken); end
        wait_cycles(1);
        checks++;
        if (beam_broken !== 1'b1) begin failures++; $display("FAIL break_level got=%b exp=1", beam_broken); end
        checks++;
        if (goal_event !== 1'b1) begin failures++; $display("FAIL break_event got=%b exp=1", goal_event); end
        checks++;
        if (goal_count !== 8'd1) begin failures++; $display("FAIL break_count got=%0d exp=1", goal_count); end
        checks++;
        if (status !== 32'h0000_0107) begin failures++; $display("FAIL break_status got=%h exp=%h", status, 32'h0000_0107); end
        wait_cycles(1);
        checks++;
        if (goal_event !== 1'b0) begin failures++; $display("FAIL break_event_width got=%b exp=0", goal_event); end
        limit_switch_raw = 1'b0;
        wait_cycles(8);
        checks++;
        if (limit_pressed !== 1'b0) begin failures++; $display("FAIL limit_release got=%b exp=0", limit_pressed); end
    endtask

    task automatic test_holdoff;
        ev0 = ev_cnt;
        beam_break_raw = 1'b1;
        wait_cycles(5);
        beam_break_raw = 1'b0;
        wait_cycles(1);
        checks++;
        if (beam_broken !== 1'b0) begin failures++; $display("FAIL restore_level got=%b exp=0", beam_broken); end
        checks++;
        if (status[3] !== 1'b1) begin failures++; $display("FAIL holdoff_active got=%b exp=1", status[3]); end
        wait_cycles(5);
        checks++;
        if (beam_broken !== 1'b1) begin failures++; $display("FAIL rebreak_level got=%b exp=1", beam_broken); end
        checks++;
        if (goal_event !== 1'b0) begin failures++; $display("FAIL rebreak_event got=%b exp=0", goal_event); end
        wait_cycles(5);
        checks++;
        if (ev_cnt - ev0 !== 0) begin failures++; $display("FAIL rebreak_events got=%0d exp=0", ev_cnt - ev0); end
        checks++;
        if (goal_count !== 8'd1) begin failures++; $display("FAIL rebreak_count got=%0d exp=1", goal_count); end

        beam_break_raw = 1'b1;
        wait_cycles(20);
        checks++;
        if (status[3] !== 1'b0) begin failures++; $display("FAIL holdoff_expired got=%b exp=0", status[3]); end
        beam_break_raw = 1'b0;
        wait_cycles(6);
        checks++;
        if (goal_event !== 1'b1) begin failures++; $display("FAIL second_goal_event got=%b exp=1", goal_event); end
        checks++;
        if (goal_count !== 8'd2) begin failures++; $display("FAIL second_goal_count got=%0d exp=2", goal_count); end
        wait_cycles(2);
        beam_break_raw = 1'b1;
        wait_cycles(20);
    endtask

    task automatic test_clear;
        beam_break_raw = 1'b0;
        wait_cycles(8);
        beam_break_raw = 1'b1;
        wait_cycles(20);
        checks++;
        if (goal_count !== 8'd3) begin failures++; $display("FAIL pre_clear_count got=%0d exp=3", goal_count); end

        beam_break_raw = 1'b0;
        wait_cycles(5);
        clear_goal = 1'b1;
        wait_cycles(1);
        clear_goal = 1'b0;
        checks++;
        if (goal_event !== 1'b1) begin failures++; $display("FAIL collide_event got=%b exp=1", goal_event); end
        checks++;
        if (goal_count !== 8'd1) begin failures++; $display("FAIL collide_count got=%0d exp=1", goal_count); end
        checks++;
        if (status[2] !== 1'b1) begin failures++; $display("FAIL collide_flag got=%b exp=1", status[2]); end
        wait_cycles(2);
        beam_break_raw = 1'b1;
        wait_cycles(20);

        clear_goal = 1'b1;
        wait_cycles(1);
        clear_goal = 1'b0;
        checks++;
        if (goal_count !== 8'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", goal_count); end
        checks++;
        if (status !== 32'h0) begin failures++; $display("FAIL clear_status got=%h exp=%h", status, 32'h0); end
    endtask

    task automatic test_saturation;
        ev0 = ev_cnt;
        for (int i = 0; i < 256; i++) begin
            beam_break_raw = 1'b0;
            wait_cycles(8);
            beam_break_raw = 1'b1;
            wait_cycles(20);
            if (i == 254) begin
                checks++;
                if (goal_count !== 8'd255) begin failures++; $display("FAIL sat_reach got=%0d exp=255", goal_count); end
            end
        end
        checks++;
        if (ev_cnt - ev0 !== 256) begin failures++; $display("FAIL sat_events got=%0d exp=256", ev_cnt - ev0); end
        checks++;
        if (goal_count !== 8'd255) begin failures++; $display("FAIL sat_count got=%0d exp=255", goal_count); end
        checks++;
        if (status[15:8] !== 8'hFF) begin failures++; $display("FAIL sat_status got=%h exp=ff", status[15:8]); end
        checks++;
        if (status[2] !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", status[2]); end
    endtask

    task automatic test_limit_reset;
        limit_switch_raw = 1'b1;
        wait_cycles(5);
        checks++;
        if (limit_pressed !== 1'b0) begin failures++; $display("FAIL limit_early got=%b exp=0", limit_pressed); end
        wait_cycles(1);
        checks++;
        if (limit_pressed !== 1'b1) begin failures++; $display("FAIL limit_level got=%b exp=1", limit_pressed); end
        checks++;
        if (status[1] !== 1'b1) begin failures++; $display("FAIL limit_status got=%b exp=1", status[1]); end
        limit_switch_raw = 1'b0;
        wait_cycles(8);

        beam_break_raw = 1'b0;
        wait_cycles(8);
        beam_break_raw = 1'b1;
        wait_cycles(9);
        checks++;
        if (status[3] !== 1'b1) begin failures++; $display("FAIL pre_reset_holdoff got=%b exp=1", status[3]); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (status !== 32'h0) begin failures++; $display("FAIL async_reset_status got=%h exp=%h", status, 32'h0); end
        wait_cycles(2);
        reset_n = 1'b1;
        ev0 = ev_cnt;
        wait_cycles(20);
        checks++;
        if (status !== 32'h0) begin failures++; $display("FAIL post_reset_status got=%h exp=%h", status, 32'h0); end
        checks++;
        if (ev_cnt - ev0 !== 0) begin failures++; $display("FAIL post_reset_events got=%0d exp=0", ev_cnt - ev0); end
        beam_break_raw = 1'b0;
        wait_cycles(6);
        checks++;
        if (goal_event !== 1'b1 || goal_count !== 8'd1) begin
            failures++; $display("FAIL idle_after_reset got=%b/%0d exp=1/1", goal_event, goal_count);
        end

        // Beam held broken across a reset is counted once after release.
        wait_cycles(4);
        reset_n = 1'b0;
        wait_cycles(3);
        ev0 = ev_cnt;
        reset_n = 1'b1;
        wait_cycles(5);
        checks++;
        if (beam_broken !== 1'b0) begin failures++; $display("FAIL held_early got=%b exp=0", beam_broken); end
        wait_cycles(1);
        checks++;
        if (goal_event !== 1'b1 || goal_count !== 8'd1 || beam_broken !== 1'b1) begin
            failures++; $display("FAIL held_goal got=%b/%0d/%b exp=1/1/1", goal_event, goal_count, beam_broken);
        end
        wait_cycles(20);
        checks++;
        if (ev_cnt - ev0 !== 1) begin failures++; $display("FAIL held_events got=%0d exp=1", ev_cnt - ev0); end
        beam_break_raw = 1'b1;
        wait_cycles(20);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_glitch();
        test_holdoff();
        test_clear();
        test_saturation();
        test_limit_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
